// File: rtl/stack_mem_responder.sv
// RAM/MMIO responder for the core's RAM interface, with a handshaked debug port on a second RAM port.
// Core reads are registered (1-cycle latency); the I/O window holds display regs and counters.
module stack_mem_responder #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [15:0] MMIO_BASE      = 16'hFF00,
  parameter logic [15:0] UNMAPPED_VALUE = 16'hDEAD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           address_ram,
  input  logic                  wren_ram,
  input  logic [15:0]           data_ram,
  output logic [15:0]           q_ram,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [15:0]           dbg_wdata,
  output logic                  dbg_ack,
  output logic [15:0]           dbg_rdata,
  output logic [15:0]           out1,
  output logic [15:0]           out2,
  output logic [15:0]           out3,
  output logic [15:0]           out4,
  output logic [15:0]           out5,
  output logic [15:0]           out6,
  output logic                  bus_error
);

  typedef enum logic [1:0] {DbgIdle, DbgAccess, DbgAck} dbg_state_e;

  logic [15:0]           mem [2**ADDR_WIDTH];
  logic [15:0]           out_q [6];
  logic [31:0]           cyc_q;
  logic [15:0]           wcnt_q;
  logic [15:0]           snap_q;
  logic [15:0]           q_d;
  dbg_state_e            dbg_state;
  logic                  dbg_we_q;
  logic [ADDR_WIDTH-1:0] dbg_addr_q;
  logic [15:0]           dbg_wdata_q;
  logic [15:0]           dbg_rd_q;

  logic                  is_ram;
  logic                  is_io;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [3:0]            io_off;

  assign is_ram  = (address_ram >> ADDR_WIDTH) == '0;
  assign is_io   = !is_ram && (address_ram[15:4] == MMIO_BASE[15:4]);
  assign ram_idx = address_ram[ADDR_WIDTH-1:0];
  assign io_off  = address_ram[3:0];

  assign out1 = out_q[0];
  assign out2 = out_q[1];
  assign out3 = out_q[2];
  assign out4 = out_q[3];
  assign out5 = out_q[4];
  assign out6 = out_q[5];

  always_comb begin
    q_d = UNMAPPED_VALUE;
    if (is_ram) begin
      // Write-first on the core port
      q_d = wren_ram ? data_ram : mem[ram_idx];
    end else if (is_io) begin
      case (io_off)
        4'd0:    q_d = out_q[0];
        4'd1:    q_d = out_q[1];
        4'd2:    q_d = out_q[2];
        4'd3:    q_d = out_q[3];
        4'd4:    q_d = out_q[4];
        4'd5:    q_d = out_q[5];
        4'd8:    q_d = cyc_q[15:0];
        4'd9:    q_d = snap_q;
        4'd10:   q_d = wcnt_q;
        default: q_d = '0;
      endcase
    end
  end

  // Core write is issued last so it wins a same-address collision with the debug port;
  // the debug read sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (dbg_state == DbgAccess) begin
      if (dbg_we_q) mem[dbg_addr_q] <= dbg_wdata_q;
      else          dbg_rd_q        <= mem[dbg_addr_q];
    end
    if (wren_ram && is_ram) mem[ram_idx] <= data_ram;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_ram       <= '0;
      for (int i = 0; i < 6; i++) out_q[i] <= '0;
      cyc_q       <= '0;
      wcnt_q      <= '0;
      snap_q      <= '0;
      bus_error   <= 1'b0;
      dbg_state   <= DbgIdle;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_ack     <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      q_ram <= q_d;
      cyc_q <= cyc_q + 32'd1;
      if (wren_ram && (is_ram || is_io)) wcnt_q <= wcnt_q + 16'd1;
      // Latch the high half alongside a low-half read for a coherent 32-bit snapshot
      if (is_io && !wren_ram && io_off == 4'd8) snap_q <= cyc_q[31:16];
      if (is_io && wren_ram) begin
        for (int i = 0; i < 6; i++) begin
          if (io_off == 4'(i)) out_q[i] <= data_ram;
        end
      end
      if (!is_ram && !is_io) bus_error <= 1'b1;

      dbg_ack <= 1'b0;
      case (dbg_state)
        DbgIdle: begin
          if (dbg_req) begin
            dbg_we_q    <= dbg_we;
            dbg_addr_q  <= dbg_addr;
            dbg_wdata_q <= dbg_wdata;
            dbg_state   <= DbgAccess;
          end
        end
        DbgAccess: dbg_state <= DbgAck;
        DbgAck: begin
          dbg_ack <= 1'b1;
          if (!dbg_we_q) dbg_rdata <= dbg_rd_q;
          dbg_state <= DbgIdle;
        end
        default: dbg_state <= DbgIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed self-checking bench for stack_mem_responder.
module tb_stack_mem_responder;

  logic        clock;
  logic        reset;
  logic [15:0] address_ram;
  logic        wren_ram;
  logic [15:0] data_ram;
  logic [15:0] q_ram;
  logic        dbg_req;
  logic        dbg_we;
  logic [9:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic [15:0] out1, out2, out3, out4, out5, out6;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  stack_mem_responder dut (
    .clock       (clock),
    .reset       (reset),
    .address_ram (address_ram),
    .wren_ram    (wren_ram),
    .data_ram    (data_ram),
    .q_ram       (q_ram),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out4        (out4),
    .out5        (out5),
    .out6        (out6),
    .bus_error   (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one core access at a negedge; returns at the next negedge, after the edge that latched it.
  task automatic core_op(input logic [15:0] addr, input logic we, input logic [15:0] data);
    address_ram = addr;
    wren_ram    = we;
    data_ram    = data;
    @(negedge clock);
    wren_ram    = 1'b0;
  endtask

  // Full debug transaction; edges counts rising edges from the one sampling dbg_req until ack.
  task automatic dbg_txn(input logic we, input logic [9:0] addr, input logic [15:0] wdata,
                         output int edges, output logic [15:0] rdata);
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    dbg_req   = 1'b1;
    edges     = 0;
    rdata     = 16'hxxxx;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (dbg_ack) begin
        rdata = dbg_rdata;
        break;
      end
    end
    dbg_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({q_ram, out1, out2, out3, out4, out5, out6, dbg_rdata} !== '0
        || dbg_ack !== 1'b0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: q=%h outs=%h %h %h %h %h %h ack=%b rdata=%h berr=%b required all 0",
               q_ram, out1, out2, out3, out4, out5, out6, dbg_ack, dbg_rdata, bus_error);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_core_ram;
    core_op(16'h0005, 1'b1, 16'h1234);
    core_op(16'h0005, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h1234) begin
      errors++; $display("FAIL ram_roundtrip: got %h required 1234", q_ram);
    end
    core_op(16'h0005, 1'b1, 16'hBEEF);
    checks++;
    if (q_ram !== 16'hBEEF) begin
      errors++; $display("FAIL ram_write_first: got %h required BEEF", q_ram);
    end
    core_op(16'h0006, 1'b1, 16'h0066);
    core_op(16'h0005, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'hBEEF) begin
      errors++; $display("FAIL ram_readback: got %h required BEEF", q_ram);
    end
  endtask

  task automatic test_display;
    core_op(16'hFF02, 1'b1, 16'h00AA);
    checks++;
    if ({out1, out2, out3, out4, out5, out6} !== {32'h0, 16'h00AA, 48'h0}) begin
      errors++;
      $display("FAIL display_write: outs %h %h %h %h %h %h required 0 0 00AA 0 0 0",
               out1, out2, out3, out4, out5, out6);
    end
    core_op(16'hFF02, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h00AA) begin
      errors++; $display("FAIL display_read: got %h required 00AA", q_ram);
    end
    core_op(16'hFF0A, 1'b1, 16'hFFFF);
    core_op(16'hFF07, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h0000 || {out1, out2, out3, out4, out5, out6} !== {32'h0, 16'h00AA, 48'h0}
        || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL display_ro_ignored: q=%h out3=%h berr=%b required q=0 out3=00AA berr=0",
               q_ram, out3, bus_error);
    end
  endtask

  task automatic test_unmapped;
    core_op(16'h0000, 1'b1, 16'h0C0C);
    core_op(16'h8000, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'hDEAD || bus_error !== 1'b1) begin
      errors++; $display("FAIL unmapped_read: q=%h berr=%b required DEAD 1", q_ram, bus_error);
    end
    core_op(16'h8000, 1'b1, 16'h7777);
    core_op(16'h0000, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h0C0C || out3 !== 16'h00AA || out1 !== 16'h0000 || bus_error !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_write: ram0=%h out1=%h out3=%h berr=%b required 0C0C 0000 00AA 1",
               q_ram, out1, out3, bus_error);
    end
  endtask

  task automatic test_debug;
    int edges;
    logic [15:0] rd;
    dbg_txn(1'b1, 10'h003, 16'h5A5A, edges, rd);
    checks++;
    if (edges !== 3) begin
      errors++; $display("FAIL dbg_write_latency: got %0d edges required 3", edges);
    end
    checks++;
    if (dbg_rdata !== 16'h0000) begin
      errors++; $display("FAIL dbg_write_rdata_kept: got %h required 0000", dbg_rdata);
    end
    dbg_txn(1'b0, 10'h003, 16'h0000, edges, rd);
    checks++;
    if (edges !== 3 || rd !== 16'h5A5A) begin
      errors++; $display("FAIL dbg_read: edges=%0d rdata=%h required 3 5A5A", edges, rd);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (dbg_rdata !== 16'h5A5A || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_rdata_hold: rdata=%h ack=%b required 5A5A 0", dbg_rdata, dbg_ack);
    end
    core_op(16'h0003, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h5A5A) begin
      errors++; $display("FAIL dbg_core_view: got %h required 5A5A", q_ram);
    end
  endtask

  task automatic test_collision;
    int n;
    logic [15:0] rd;
    // Debug write and core write land on address 4 at the same ACCESS edge
    dbg_we = 1'b1; dbg_addr = 10'h004; dbg_wdata = 16'h2222; dbg_req = 1'b1;
    @(negedge clock);
    address_ram = 16'h0004; wren_ram = 1'b1; data_ram = 16'h1111;
    @(negedge clock);
    wren_ram = 1'b0; address_ram = 16'h0000;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      n++;
      if (dbg_ack) break;
    end
    dbg_req = 1'b0;
    @(negedge clock);
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL collision_ack: ack after %0d edges required 1", n);
    end
    core_op(16'h0004, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h1111) begin
      errors++; $display("FAIL collision_core_wins: got %h required 1111", q_ram);
    end
    // Debug read of address 4 while the core overwrites it at the ACCESS edge
    dbg_we = 1'b0; dbg_addr = 10'h004; dbg_req = 1'b1;
    @(negedge clock);
    address_ram = 16'h0004; wren_ram = 1'b1; data_ram = 16'h3333;
    @(negedge clock);
    wren_ram = 1'b0; address_ram = 16'h0000;
    rd = 16'hxxxx;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (dbg_ack) begin
        rd = dbg_rdata;
        break;
      end
    end
    dbg_req = 1'b0;
    @(negedge clock);
    core_op(16'h0004, 1'b0, 16'h0000);
    checks++;
    if (rd !== 16'h1111 || q_ram !== 16'h3333) begin
      errors++;
      $display("FAIL collision_read_old: dbg=%h core=%h required 1111 3333", rd, q_ram);
    end
  endtask

  task automatic test_reset_mid;
    int edges;
    logic [15:0] rd;
    logic saw_ack;
    core_op(16'h0005, 1'b0, 16'h0000);
    dbg_we = 1'b0; dbg_addr = 10'h003; dbg_req = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({q_ram, out1, out2, out3, out4, out5, out6, dbg_rdata} !== '0
        || dbg_ack !== 1'b0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: q=%h out3=%h ack=%b rdata=%h berr=%b required all 0",
               q_ram, out3, dbg_ack, dbg_rdata, bus_error);
    end
    dbg_req = 1'b0;
    saw_ack = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
      if (dbg_ack) saw_ack = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (dbg_ack) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_ack: ack seen=%b required 0", saw_ack);
    end
    @(negedge clock);
    dbg_txn(1'b0, 10'h003, 16'h0000, edges, rd);
    checks++;
    if (edges !== 3 || rd !== 16'h5A5A) begin
      errors++; $display("FAIL reset_mid_recover: edges=%0d rdata=%h required 3 5A5A", edges, rd);
    end
  endtask

  task automatic test_counters;
    reset = 1'b1;
    @(negedge clock);
    // Release here: the next rising edge is counter edge 1
    reset = 1'b0;
    core_op(16'h0005, 1'b1, 16'h0055);
    core_op(16'h0006, 1'b1, 16'h0066);
    core_op(16'hFF00, 1'b1, 16'h0101);
    address_ram = 16'h0000;
    repeat (69997) @(posedge clock);
    @(negedge clock);
    // Counter is 70000 = 0x0001_1170 when this read is latched
    core_op(16'hFF08, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h1170) begin
      errors++; $display("FAIL cycle_lo: got %h required 1170", q_ram);
    end
    core_op(16'hFF00, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h0101 || out1 !== 16'h0101) begin
      errors++; $display("FAIL out1_after_reset: q=%h out1=%h required 0101 0101", q_ram, out1);
    end
    repeat (4) core_op(16'h0005, 1'b0, 16'h0000);
    core_op(16'hFF09, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h0001) begin
      errors++; $display("FAIL cycle_hi_snapshot: got %h required 0001", q_ram);
    end
    core_op(16'hFF0A, 1'b0, 16'h0000);
    checks++;
    if (q_ram !== 16'h0003) begin
      errors++; $display("FAIL write_count: got %h required 0003", q_ram);
    end
  endtask

  initial begin
    reset = 1'b1; address_ram = '0; wren_ram = 1'b0; data_ram = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    @(negedge clock);
    test_reset;
    test_core_ram;
    test_display;
    test_unmapped;
    test_debug;
    test_collision;
    test_reset_mid;
    test_counters;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
